// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered RV32I decode stage. Each raw instruction word accepted on the
// input handshake is decoded combinationally (fields, format, sign-extended
// immediate, legality) and written together with its PC into a DEPTH-entry
// FIFO. The FIFO head drives the execute-facing outputs.
//
// Build option:
//   DECODE_M_EXT_EN  - when defined, R-type words with func7 = 0x01 are legal
//                      and flagged on out_muldiv; otherwise they are illegal
//                      and out_muldiv is always 0.
//
// Parameters:
//   XLEN   immediate width (32 or 64), sign-extended from instr[31]
//   PC_W   width of the PC carried with each instruction
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   flush             synchronous clear of every buffered entry
//   in_valid/in_ready input handshake; in_ready = !full
//   in_instr, in_pc   instruction word and its PC
//   out_valid/out_ready output handshake; out_valid = !empty
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_func3, out_func7
//                     fields of the head entry
//   out_fmt           R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   out_imm           immediate of the head entry (0 for R and NONE)
//   out_illegal       head entry is an illegal encoding
//   out_muldiv        head entry is an M-extension op
//   decode_count      number of legal entries popped (wraps)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic            out_muldiv,
    output logic [31:0]     decode_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ---------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------------
    logic [6:0]      dec_opc;
    logic [2:0]      dec_f3;
    logic [6:0]      dec_f7;
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic            dec_md;

    assign dec_opc = in_instr[6:0];
    assign dec_f3  = in_instr[14:12];
    assign dec_f7  = in_instr[31:25];

    always_comb begin
        dec_fmt = FMT_NONE;
        case (dec_opc)
            OPC_OP:                                  dec_fmt = FMT_R;
            OPC_OPIMM, OPC_LOAD, OPC_JALR,
            OPC_FENCE, OPC_SYSTEM:                   dec_fmt = FMT_I;
            OPC_STORE:                               dec_fmt = FMT_S;
            OPC_BRANCH:                              dec_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                      dec_fmt = FMT_U;
            OPC_JAL:                                 dec_fmt = FMT_J;
            default:                                 dec_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
            FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_sext
            assign dec_imm = {{(XLEN - 32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_nosext
            assign dec_imm = dec_imm32;
        end
    endgenerate

    always_comb begin
        dec_ill = 1'b0;
        dec_md  = 1'b0;
        if (in_instr[1:0] != 2'b11 || dec_fmt == FMT_NONE) begin
            dec_ill = 1'b1;
        end
        case (dec_opc)
            OPC_LOAD:   if (dec_f3 == 3'd3 || dec_f3 == 3'd6 || dec_f3 == 3'd7) dec_ill = 1'b1;
            OPC_STORE:  if (dec_f3 > 3'd2) dec_ill = 1'b1;
            OPC_BRANCH: if (dec_f3 == 3'd2 || dec_f3 == 3'd3) dec_ill = 1'b1;
            OPC_JALR:   if (dec_f3 != 3'd0) dec_ill = 1'b1;
            OPC_OPIMM: begin
                // Shift-immediates reuse func7 as a qualifier.
                if (dec_f3 == 3'd1 && dec_f7 != 7'h00) dec_ill = 1'b1;
                if (dec_f3 == 3'd5 && dec_f7 != 7'h00 && dec_f7 != 7'h20) dec_ill = 1'b1;
            end
            OPC_OP: begin
                if (dec_f7 == 7'h20) begin
                    // Only SUB and SRA exist with the alternate func7.
                    if (dec_f3 != 3'd0 && dec_f3 != 3'd5) dec_ill = 1'b1;
                end else if (dec_f7 != 7'h00) begin
`ifdef DECODE_M_EXT_EN
                    if (dec_f7 == 7'h01) dec_md  = 1'b1;
                    else                 dec_ill = 1'b1;
`else
                    dec_ill = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   dcount_q, dcount_d;
    logic          push, pop, wr_en;

    logic [PC_W-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [2:0]      fmt_mem_q   [DEPTH];
    logic [XLEN-1:0] imm_mem_q   [DEPTH];
    logic            ill_mem_q   [DEPTH];
    logic            md_mem_q    [DEPTH];

    // in_ready looks only at occupancy, so a pop cannot free a slot for a
    // push within the same cycle.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dcount_d = dcount_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
            if (pop && !ill_mem_q[rd_ptr_q]) dcount_d = dcount_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dcount_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                fmt_mem_q[i]   <= '0;
                imm_mem_q[i]   <= '0;
                ill_mem_q[i]   <= 1'b0;
                md_mem_q[i]    <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dcount_q <= dcount_d;
            if (wr_en) begin
                pc_mem_q[wr_ptr_q]    <= in_pc;
                instr_mem_q[wr_ptr_q] <= in_instr;
                fmt_mem_q[wr_ptr_q]   <= dec_fmt;
                imm_mem_q[wr_ptr_q]   <= dec_imm;
                ill_mem_q[wr_ptr_q]   <= dec_ill;
                md_mem_q[wr_ptr_q]    <= dec_md;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Head entry outputs (all straight from stored state)
    // ---------------------------------------------------------------------
    logic [31:0] head_instr;
    assign head_instr   = instr_mem_q[rd_ptr_q];

    assign out_pc       = pc_mem_q[rd_ptr_q];
    assign out_opcode   = head_instr[6:0];
    assign out_rd       = head_instr[11:7];
    assign out_func3    = head_instr[14:12];
    assign out_rs1      = head_instr[19:15];
    assign out_rs2      = head_instr[24:20];
    assign out_func7    = head_instr[31:25];
    assign out_fmt      = fmt_mem_q[rd_ptr_q];
    assign out_imm      = imm_mem_q[rd_ptr_q];
    assign out_illegal  = ill_mem_q[rd_ptr_q];
    assign out_muldiv   = md_mem_q[rd_ptr_q];
    assign decode_count = dcount_q;

endmodule
